// File: rtl/ws2812_frame_sched_if.sv
// Pixel RAM read port plus serializer handshake, driven by ws2812_frame_sched.
// The scheduler takes the master modport; the RAM/serializer side takes slave.
interface ws2812_frame_sched_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic [23:0]       px_data;
  logic              px_valid;
  logic              px_ready;
  logic              ser_busy;

  modport master (
    output rd_addr, px_data, px_valid,
    input  rd_data, px_ready, ser_busy
  );

  modport slave (
    input  rd_addr, px_data, px_valid,
    output rd_data, px_ready, ser_busy
  );
endinterface

// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: walks the pixel buffer once per frame tick or trig, feeds the
// serializer, waits for drain, then holds the latch gap. WS2812_BRIGHTNESS_EN adds scaling.
module ws2812_frame_sched #(
  parameter int NUM_LEDS     = 60,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = 3600,
  parameter int FRAME_CYCLES = 240000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trig,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  ws2812_frame_sched_if.master bus,
  output logic        frame_active,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] frame_cnt
);
  localparam int TW = $clog2(FRAME_CYCLES);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [TW-1:0]     TIMER_RELOAD = TW'(FRAME_CYCLES - 1);
  localparam logic [LW-1:0]     LATCH_RELOAD = LW'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
`ifdef WS2812_BRIGHTNESS_EN
    SCALE,
`endif
    SEND,
    DRAIN,
    LATCH
  } state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [LW-1:0]     latch_cnt;
  logic [ADDR_W-1:0] idx;
  logic              pending;
  logic              tick;
  logic              req;
  logic              start;

`ifdef WS2812_BRIGHTNESS_EN
  // (c * (b + 1)) >> 8 : b = 255 is an exact pass-through, b = 0 blanks the channel.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
  endfunction
`endif

  assign tick        = enable && (timer == '0);
  assign req         = tick || trig;
  assign start       = (state == IDLE) && pending;
  assign bus.rd_addr = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= TIMER_RELOAD;
    end else if (timer == '0) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - 1'b1;
    end
  end

  // A request arriving in the same cycle IDLE consumes the old one stays queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (req) begin
        pending <= 1'b1;
      end else if (start) begin
        pending <= 1'b0;
      end
      if (req && pending) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      latch_cnt    <= '0;
      bus.px_data  <= '0;
      bus.px_valid <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            idx          <= '0;
            frame_active <= 1'b1;
            state        <= FETCH;
          end else begin
            frame_active <= req;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          bus.px_data <= bus.rd_data;
`ifdef WS2812_BRIGHTNESS_EN
          state <= SCALE;
`else
          bus.px_valid <= 1'b1;
          state        <= SEND;
`endif
        end
`ifdef WS2812_BRIGHTNESS_EN
        SCALE: begin
          bus.px_data  <= {scale_ch(bus.px_data[23:16], brightness),
                           scale_ch(bus.px_data[15:8],  brightness),
                           scale_ch(bus.px_data[7:0],   brightness)};
          bus.px_valid <= 1'b1;
          state        <= SEND;
        end
`endif
        SEND: begin
          if (bus.px_ready) begin
            bus.px_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= DRAIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        DRAIN: begin
          if (!bus.ser_busy) begin
            latch_cnt <= LATCH_RELOAD;
            state     <= LATCH;
          end
        end
        LATCH: begin
          if (latch_cnt == '0) begin
            frame_done   <= 1'b1;
            frame_cnt    <= frame_cnt + 1'b1;
            frame_active <= pending || req;
            state        <= IDLE;
          end else begin
            latch_cnt <= latch_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
